// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioner: channel indices, channel FSM
// encoding and default timing in clock cycles.
package btn_pkg;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_INC   = 2;
    localparam int BTN_DEC   = 3;

    localparam int DEF_DB_CYCLES     = 1_000_000;
    localparam int DEF_HOLD_CYCLES   = 50_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce counter and press/hold/repeat FSM
// producing a combinational single-cycle event strobe.
module btn_channel
    import btn_pkg::*;
#(
    parameter int   DB_CYCLES     = DEF_DB_CYCLES,
    parameter int   HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int   REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter logic REPEAT_EN     = 1'b0,
    parameter int   CW            = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic held,
    output logic evt
);

    logic [1:0]    sync_q;
    logic [CW-1:0] db_cnt;
    logic [CW-1:0] tmr, tmr_next;
    state_t        state, state_next;

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            db_cnt <= '0;
            held   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (sync_q[1] == held) begin
                db_cnt <= '0;
            end else if (db_cnt == CW'(DB_CYCLES - 1)) begin
                held   <= ~held;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_next;
            tmr   <= tmr_next;
        end
    end

    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        state_next = state;
        tmr_next   = tmr;
        evt        = 1'b0;
        case (state)
            ST_IDLE: begin
                tmr_next = '0;
                if (held) begin
                    evt        = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr == CW'(HOLD_CYCLES - 1)) begin
                    // Without repeat the timer parks at expiry until release.
                    if (REPEAT_EN) begin
                        evt        = 1'b1;
                        state_next = ST_REPEAT;
                        tmr_next   = '0;
                    end
                end else begin
                    tmr_next = tmr + CW'(1);
                end
            end
            ST_REPEAT: begin
                if (tmr == CW'(REPEAT_CYCLES - 1)) begin
                    evt      = 1'b1;
                    tmr_next = '0;
                end else begin
                    tmr_next = tmr + CW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (!held) begin
            state_next = ST_IDLE;
            tmr_next   = '0;
            evt        = 1'b0;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Four conditioned button channels feeding pending bits and a fixed-priority arbiter
// that emits at most one registered event pulse per cycle.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int         DB_CYCLES     = DEF_DB_CYCLES,
    parameter int         HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int         REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter logic [3:0] REPEAT_MASK   = 4'b1100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    input  logic       en,
    output logic       left,
    output logic       right,
    output logic       inc,
    output logic       dec,
    output logic [3:0] held
);

    localparam int CW = $clog2(max3(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES));

    generate
        if (DB_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
            $error("btn_conditioner: all timing parameters must be >= 2");
        end
    endgenerate

    logic [3:0] evt;
    logic [3:0] pending;
    logic [3:0] req;
    logic [3:0] grant;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        btn_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .REPEAT_EN    (REPEAT_MASK[i]),
            .CW           (CW)
        ) u_ch (
            .clk (clk),
            .rst (rst),
            .raw (btn_raw[i]),
            .held(held[i]),
            .evt (evt[i])
        );
    end

    // Fresh events join the request set directly so an uncontended press is not
    // delayed by a pass through the pending register; lowest index wins.
    assign req   = en ? (pending | evt) : 4'b0000;
    assign grant = req & (~req + 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            left    <= 1'b0;
            right   <= 1'b0;
            inc     <= 1'b0;
            dec     <= 1'b0;
        end else begin
            pending <= req & ~grant;
            left    <= grant[BTN_LEFT];
            right   <= grant[BTN_RIGHT];
            inc     <= grant[BTN_INC];
            dec     <= grant[BTN_DEC];
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with short timing (DB=4, HOLD=10, REPEAT=3):
// drivers queue expected pulses, a monitor pops and compares each observed pulse.
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'b0000;
    logic       en = 1'b1;
    logic       left, right, inc, dec;
    logic [3:0] held;

    typedef struct {
        int         cyc;
        logic [3:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    btn_conditioner #(
        .DB_CYCLES    (4),
        .HOLD_CYCLES  (10),
        .REPEAT_CYCLES(3),
        .REPEAT_MASK  (4'b1100)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .en     (en),
        .left   (left),
        .right  (right),
        .inc    (inc),
        .dec    (dec),
        .held   (held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic expect_pulse(input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    function automatic int pulses();
        return int'({dec, inc, right, left});
    endfunction

    // Monitor: every observed pulse must match the head of the expectation queue.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && pulses() != 0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", pulses(), 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_vec", pulses(), int'(e.v));
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int base, f, r;

        // Reset state
        step();
        check("rst_outputs", pulses(), 0);
        check("rst_held", int'(held), 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_outputs", pulses(), 0);
        wait_until(cyc + 5);

        // 1: left press, no repeat
        base = cyc;
        btn_raw = 4'b0001;
        expect_pulse(base + 7, 4'b0001);
        wait_until(base + 5);
        check("t1_held_pre", int'(held), 0);
        wait_until(base + 6);
        check("t1_held_rise", int'(held), 4'b0001);
        wait_until(base + 30);
        btn_raw = 4'b0000;
        wait_until(base + 45);
        check("t1_held_fall", int'(held), 0);
        check("t1_drain", exp_q.size(), 0);

        // 2: inc held with auto-repeat, release at +24 (held falls at +30)
        base = cyc;
        btn_raw = 4'b0100;
        expect_pulse(base + 7, 4'b0100);
        expect_pulse(base + 17, 4'b0100);
        expect_pulse(base + 20, 4'b0100);
        expect_pulse(base + 23, 4'b0100);
        expect_pulse(base + 26, 4'b0100);
        expect_pulse(base + 29, 4'b0100);
        wait_until(base + 24);
        btn_raw = 4'b0000;
        wait_until(base + 29);
        check("t2_held_still", int'(held), 4'b0100);
        wait_until(base + 30);
        check("t2_held_fall", int'(held), 0);
        wait_until(base + 50);
        check("t2_drain", exp_q.size(), 0);

        // 3: dec with 2-cycle bounce, then a clean press released before repeat
        base = cyc;
        for (int i = 0; i < 12; i++) begin
            btn_raw[3] = ((i / 2) % 2) == 0;
            step();
        end
        f = cyc;
        btn_raw[3] = 1'b1;
        expect_pulse(f + 7, 4'b1000);
        wait_until(f + 5);
        check("t3_held_bounce", int'(held), 0);
        wait_until(f + 6);
        check("t3_held_rise", int'(held), 4'b1000);
        wait_until(f + 9);
        btn_raw = 4'b0000;
        wait_until(f + 35);
        check("t3_drain", exp_q.size(), 0);

        // 4: left and right together, arbitrated on consecutive cycles
        base = cyc;
        btn_raw = 4'b0011;
        expect_pulse(base + 7, 4'b0001);
        expect_pulse(base + 8, 4'b0010);
        wait_until(base + 6);
        check("t4_held", int'(held), 4'b0011);
        wait_until(base + 20);
        btn_raw = 4'b0000;
        wait_until(base + 35);
        check("t4_drain", exp_q.size(), 0);

        // 5: enable low over the press, raised mid-hold
        base = cyc;
        en = 1'b0;
        btn_raw = 4'b0100;
        expect_pulse(base + 17, 4'b0100);
        expect_pulse(base + 20, 4'b0100);
        expect_pulse(base + 23, 4'b0100);
        wait_until(base + 12);
        check("t5_held_while_disabled", int'(held), 4'b0100);
        en = 1'b1;
        wait_until(base + 18);
        btn_raw = 4'b0000;
        wait_until(base + 40);
        check("t5_drain", exp_q.size(), 0);

        // 6: reset during hold; still-pressed button re-debounces after release
        base = cyc;
        btn_raw = 4'b0100;
        expect_pulse(base + 7, 4'b0100);
        wait_until(base + 15);
        rst = 1'b1;
        #1;
        check("t6_rst_outputs", pulses(), 0);
        check("t6_rst_held", int'(held), 0);
        step();
        step();
        rst = 1'b0;
        r = cyc;
        expect_pulse(r + 7, 4'b0100);
        step();
        check("t6_post_rst_outputs", pulses(), 0);
        wait_until(r + 6);
        check("t6_held_again", int'(held), 4'b0100);
        wait_until(r + 9);
        btn_raw = 4'b0000;
        wait_until(r + 35);
        check("t6_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
